// File: rtl/cra_next_adr.sv
`default_nettype none
// ============================================================================
// Module      : cra_next_adr
// Description : Microcode next-address sequencer. It selects the dispatch
//               base, applies the skip, and maintains the call/return stack.
// Revision    : 1.0 - initial release
// ============================================================================
module cra_next_adr #(
    parameter int ADDR_W      = 11,
    parameter int STACK_DEPTH = 16
) (
    input  logic              eboxClk,
    input  logic              eboxReset_n,
    input  logic [ADDR_W-1:0] cramJ,
    input  logic [4:0]        cramDisp,
    input  logic              cramCall,
    input  logic              skipEn,
    input  logic              skipTaken,
    input  logic [ADDR_W-1:0] dispData,
    input  logic              hold,
    input  logic              conLoad,
    input  logic [ADDR_W-1:0] conAdr,
    output logic [ADDR_W-1:0] CRADR,
    output logic [4:0]        stackDepth,
    output logic              stackOvf,
    output logic              stackUnf
);

    localparam logic [4:0] c_DISP_RETURN = 5'o01;
    localparam logic [4:0] c_DISP_OR4    = 5'o02;
    localparam logic [4:0] c_DISP_OR8    = 5'o03;
    localparam logic [4:0] c_DISP_JUMP   = 5'o04;
    localparam int         c_IDX_W       = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [4:0] c_FULL        = 5'(STACK_DEPTH);

    logic [ADDR_W-1:0]  r_cradr;
    logic [4:0]         r_depth;
    logic               r_ovf;
    logic               r_unf;
    logic [ADDR_W-1:0]  r_stack [STACK_DEPTH];

    logic               w_ret;
    logic [c_IDX_W-1:0] w_top_idx;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [ADDR_W-1:0]  w_top;
    logic [ADDR_W-1:0]  w_base;
    logic [ADDR_W-1:0]  w_next_adr;
    logic [4:0]         w_pop_depth;
    logic [4:0]         w_next_depth;
    logic               w_unf_evt;
    logic               w_full;
    logic               w_push;
    logic               w_ovf_evt;
    logic               w_advance;

    assign w_ret     = (cramDisp == c_DISP_RETURN);
    assign w_top_idx = c_IDX_W'(r_depth - 5'd1);
    assign w_top     = (r_depth != 5'd0) ? r_stack[w_top_idx] : '0;
    assign w_advance = !conLoad && !hold;

    always_comb begin
        w_base = cramJ;
        case (cramDisp)
            c_DISP_RETURN: w_base = w_top | cramJ;
            c_DISP_OR4:    w_base = cramJ | {{(ADDR_W-4){1'b0}}, dispData[3:0]};
            c_DISP_OR8:    w_base = cramJ | {{(ADDR_W-8){1'b0}}, dispData[7:0]};
            c_DISP_JUMP:   w_base = dispData;
            default:       w_base = cramJ;
        endcase
        w_next_adr = w_base | {{(ADDR_W-1){1'b0}}, skipEn & skipTaken};
    end

    // The pop is resolved first so a call in the same cycle reuses the freed slot.
    always_comb begin
        w_pop_depth  = (w_ret && (r_depth != 5'd0)) ? (r_depth - 5'd1) : r_depth;
        w_unf_evt    = w_ret && (r_depth == 5'd0);
        w_full       = (w_pop_depth == c_FULL);
        w_push       = cramCall && !w_full;
        w_ovf_evt    = cramCall && w_full;
        w_next_depth = w_push ? (w_pop_depth + 5'd1) : w_pop_depth;
        w_wr_idx     = w_pop_depth[c_IDX_W-1:0];
    end

    always_ff @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n) begin
            r_cradr <= '0;
            r_depth <= 5'd0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (conLoad) begin
            r_cradr <= conAdr;
            r_depth <= 5'd0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (!hold) begin
            r_cradr <= w_next_adr;
            r_depth <= w_next_depth;
            r_ovf   <= r_ovf | w_ovf_evt;
            r_unf   <= r_unf | w_unf_evt;
        end
    end

    always_ff @(posedge eboxClk) begin
        if (eboxReset_n && w_advance && w_push) begin
            r_stack[w_wr_idx] <= r_cradr;
        end
    end

    assign CRADR      = r_cradr;
    assign stackDepth = r_depth;
    assign stackOvf   = r_ovf;
    assign stackUnf   = r_unf;

endmodule
`default_nettype wire
